game_link_tx: RTL
=================

# game_link_tx

Frame transmitter for the two-board game link. It sends START and SCORE messages to the opponent board over a UART 8N1 line. It is the transmit end of the link whose receiver produces `uart_start` and `op_score` for the game state machine. It sits in the `pclk` domain next to the state machine, which pulses its requests.

## Interface
Parameters:
- `CLK_HZ`, 75_000_000: `pclk` frequency in Hz.
- `BAUD`, 115_200: line rate. Bit period `DIV = CLK_HZ / BAUD`, integer-truncated (651 at defaults). Must be ≥ 2.

Ports:
- `pclk`, in, 1: the only clock; everything is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_start`, in, 1: one-cycle pulse requesting a START frame.
- `req_score`, in, 1: one-cycle pulse requesting a SCORE frame.
- `score`, in, 16: own score, BCD/ASCII pair as produced by the game logic.
- `tx`, out, 1: serial line. Idle is high.
- `busy`, out, 1: high while a frame is on the line.
- `done`, out, 1: one-cycle pulse at the end of each frame.

## Operation
- Every frame is 5 bytes, in this order: `8'hA5` (sync), type, payload_hi, payload_lo, checksum.
  - START: type `8'h01`, payload `16'h0000`.
  - SCORE: type `8'h02`, payload = `score` snapshot.
- Checksum = type ^ payload_hi ^ payload_lo.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly `DIV` cycles.
- Requests set sticky flags `pend_start` / `pend_score`.
  - A repeated request while its flag is already set merges into it; it is not queued twice.
  - A flag clears on the cycle its frame is launched.
- Arbitration at launch: START wins over SCORE when both are pending. SCORE is sent as the next frame.
- `score` is captured at launch. Changes to `score` during the frame do not affect the frame.
- Frame FSM states: IDLE → SYNC → TYPE → PHI → PLO → CHK → IDLE.
  - IDLE advances when any flag is set.
  - Each data state advances when its byte's stop bit completes.
- Bit serializer states: START_BIT → DATA (bit index 0..7) → STOP_BIT.
  - It has a bit counter and a baud counter 0..DIV-1.
  - The baud counter wraps at DIV-1 and advances the bit.
- Back-to-back frames: if a flag is pending when CHK's stop bit ends, the next start bit follows with no idle gap.
- Reset, asserted at any time: the current frame is aborted, flags are cleared and counters are zeroed. `tx`=1, `busy`=0 and `done`=0 immediately; this is asynchronous and needs no clock.
- Requests arriving during reset are ignored.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM=IDLE.
- A request pulse sampled at edge N sets its flag at edge N. From IDLE, the frame launches at edge N+1: `tx` falls and `busy` rises, both registered.
- A request and a launch on the same edge: a request that arrives on the launch edge of a different frame type stays pending.
- Frame length is exactly 50·DIV cycles from the `tx` fall to the end of the last stop bit.
- On the edge that ends the last stop bit:
  - `done`=1 for one cycle.
  - If nothing is pending, `busy`=0 on that same edge.
  - If something is pending, `busy` stays 1 and the next start bit begins on that same edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `game_link_pkg` holds:
  - `SYNC_BYTE` = `8'hA5`.
  - `TYPE_START` = `8'h01`, `TYPE_SCORE` = `8'h02`.
  - `FRAME_BYTES` = 5.
  - The frame-state enum.
- The same package is shared with the link receiver, so both ends agree on these values.
- One sub-module, `uart_tx_byte`:
  - Ports: `pclk`, `rst`, `load`, `data[7:0]`, `tx`, `byte_done`.
  - Parameter `DIV`.
  - Contains the baud counter and bit serializer.
- The top level holds the request flags, arbitration, score snapshot, checksum and frame FSM.

## Test plan
All scenarios use CLK_HZ=16, BAUD=1 (DIV=16). Decode `tx` by sampling at bit centers.
- Reset idle: hold `rst`=0 for 5 cycles, then release → `tx`=1, `busy`=0, `done`=0, and no edge on `tx` for 2000 cycles.
- SCORE frame: `score`=16'h1234, pulse `req_score` → `tx` falls 1 cycle after the flag sets. Bytes A5 02 12 34 24 are decoded. `done` pulses exactly 800 cycles after the `tx` fall.
- Simultaneous requests: `req_start` and `req_score` pulsed on the same cycle with `score`=16'h3132 → bytes A5 01 00 00 01, then immediately A5 02 31 32 01 (checksum 02^31^32). There is no idle gap, `busy` stays high for 1600 cycles, and `done` pulses twice.
- Snapshot and merge: during a START frame, pulse `req_score` three times and change `score` from 16'h0001 to 16'h0099 → exactly one SCORE frame follows, carrying the value of `score` at its launch (A5 02 00 99 9B).
- Reset mid-frame: assert `rst` at the 3rd data bit of the TYPE byte → `tx`=1 and `busy`=0 immediately. After release with no request, the line stays idle, and a later `req_start` yields a complete, clean START frame.

Source files
------------

// File: rtl/game_link_pkg.sv
// Shared constants and state types for both ends of the two-board game link.
package game_link_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] TYPE_START = 8'h01;
    localparam logic [7:0] TYPE_SCORE = 8'h02;
    localparam int unsigned FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_SYNC,
        FR_TYPE,
        FR_PHI,
        FR_PLO,
        FR_CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START_BIT,
        SER_DATA,
        SER_STOP_BIT
    } ser_state_t;

    function automatic logic [7:0] frame_checksum(input logic [7:0] typ, input logic [15:0] payload);
        return typ ^ payload[15:8] ^ payload[7:0];
    endfunction

endpackage

// File: rtl/game_link_tx_uart.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each DIV cycles long.
module uart_tx_byte
    import game_link_pkg::*;
#(
    parameter int unsigned DIV = 651
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    ser_state_t    state, state_nx;
    logic [CW-1:0] baud_cnt, baud_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          tx_nx;

    // Combinational so the frame FSM can reload on the very edge the stop bit ends.
    assign byte_done = (state == SER_STOP_BIT) && (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx_nx    = tx;
        if (load) begin
            state_nx = SER_START_BIT;
            baud_nx  = '0;
            bit_nx   = '0;
            shreg_nx = data;
            tx_nx    = 1'b0;
        end else if (state != SER_IDLE) begin
            if (baud_cnt != BAUD_LAST) begin
                baud_nx = baud_cnt + CW'(1);
            end else begin
                baud_nx = '0;
                case (state)
                    SER_START_BIT: begin
                        state_nx = SER_DATA;
                        tx_nx    = shreg[0];
                        shreg_nx = {1'b0, shreg[7:1]};
                    end
                    SER_DATA: begin
                        if (bit_idx == 3'd7) begin
                            state_nx = SER_STOP_BIT;
                            tx_nx    = 1'b1;
                        end else begin
                            bit_nx   = bit_idx + 3'd1;
                            tx_nx    = shreg[0];
                            shreg_nx = {1'b0, shreg[7:1]};
                        end
                    end
                    SER_STOP_BIT: state_nx = SER_IDLE;
                    default:      state_nx = SER_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state    <= SER_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
            tx       <= tx_nx;
        end
    end

endmodule

// File: rtl/game_link_tx.sv
// Game link transmitter: request flags, START/SCORE arbitration and 5-byte frame sequencing.
module game_link_tx
    import game_link_pkg::*;
#(
    parameter int unsigned CLK_HZ = 75_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        req_start,
    input  logic        req_score,
    input  logic [15:0] score,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    frame_state_t state, state_nx;
    logic         pend_start, pend_score;
    logic [7:0]   cur_type;
    logic [15:0]  payload;
    logic         launch, load, end_frame, byte_done;
    logic [7:0]   load_data;

    always_comb begin
        state_nx  = state;
        launch    = 1'b0;
        load      = 1'b0;
        end_frame = 1'b0;
        load_data = SYNC_BYTE;
        case (state)
            FR_IDLE: begin
                if (pend_start || pend_score) begin
                    launch   = 1'b1;
                    load     = 1'b1;
                    state_nx = FR_SYNC;
                end
            end
            FR_SYNC: if (byte_done) begin
                load      = 1'b1;
                load_data = cur_type;
                state_nx  = FR_TYPE;
            end
            FR_TYPE: if (byte_done) begin
                load      = 1'b1;
                load_data = payload[15:8];
                state_nx  = FR_PHI;
            end
            FR_PHI: if (byte_done) begin
                load      = 1'b1;
                load_data = payload[7:0];
                state_nx  = FR_PLO;
            end
            FR_PLO: if (byte_done) begin
                load      = 1'b1;
                load_data = frame_checksum(cur_type, payload);
                state_nx  = FR_CHK;
            end
            FR_CHK: if (byte_done) begin
                end_frame = 1'b1;
                // Relaunch on the same edge so back-to-back frames have no idle gap.
                if (pend_start || pend_score) begin
                    launch   = 1'b1;
                    load     = 1'b1;
                    state_nx = FR_SYNC;
                end else begin
                    state_nx = FR_IDLE;
                end
            end
            default: state_nx = FR_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= FR_IDLE;
            pend_start <= 1'b0;
            pend_score <= 1'b0;
            cur_type   <= '0;
            payload    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != FR_IDLE);
            done       <= end_frame;
            // A request on the launch edge of its own type merges into that frame.
            pend_start <= (launch && pend_start) ? 1'b0 : (pend_start | req_start);
            pend_score <= (launch && !pend_start && pend_score) ? 1'b0 : (pend_score | req_score);
            if (launch) begin
                cur_type <= pend_start ? TYPE_START : TYPE_SCORE;
                payload  <= pend_start ? 16'h0000 : score;
            end
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_uart (
        .pclk      (pclk),
        .rst       (rst),
        .load      (load),
        .data      (load_data),
        .tx        (tx),
        .byte_done (byte_done)
    );

endmodule
